// File: rtl/delay_pkg.sv
// Shared definitions for the multichannel delay line: delay fixed-point type,
// maximum-delay computation and packed-lane index helpers.
package delay_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_FRAC_W = 4;

    // Unsigned fixed-point delay in samples for the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] intg;
        logic [DEF_FRAC_W-1:0] frac;
    } delay_t;

    // Two slots short of full depth so that both the D and D+1 taps stay
    // inside the buffer without colliding with the write slot.
    function automatic int max_delay(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

    function automatic int lane_lo(input int ch, input int w);
        return ch * w;
    endfunction

    function automatic int lane_hi(input int ch, input int w);
        return ch * w + w - 1;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// One channel's circular sample buffer: single write port, two asynchronous
// read ports. Slots not written since reset read back as zero.
module delay_ram
    import delay_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0]        raddr0,
    input  logic [ADDR_W-1:0]        raddr1,
    output logic signed [DATA_W-1:0] rdata0,
    output logic signed [DATA_W-1:0] rdata1
);

    localparam int DEPTH = 1 << ADDR_W;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]         written;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    // Per-slot written flags stand in for clearing the whole array on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written <= '0;
        end else if (we) begin
            written[waddr] <= 1'b1;
        end
    end

    assign rdata0 = written[raddr0] ? mem[raddr0] : '0;
    assign rdata1 = written[raddr1] ? mem[raddr1] : '0;

endmodule

// File: rtl/multich_delay_line.sv
// NUM_CH-channel fractional-capable delay line with shadowed per-channel delays.
// Optional linear interpolation on the fractional delay: DELAY_FRAC_INTERP_EN.
module multich_delay_line
    import delay_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 19,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_valid,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [ADDR_W+FRAC_W-1:0]   cfg_delay,
    output logic                       cfg_clamped
);

    localparam int DLY_W = ADDR_W + FRAC_W;
    localparam int VEC_W = NUM_CH * DATA_W;
    localparam int MAX_D = max_delay(ADDR_W);

`ifdef DELAY_FRAC_INTERP_EN
    localparam int PW = DATA_W + FRAC_W + 1;

    // x0 + F*(x1-x0)/2^FRAC_W; the arithmetic shift floors toward -inf.
    function automatic logic signed [DATA_W-1:0] interp(
        input logic signed [DATA_W-1:0] x0,
        input logic signed [DATA_W-1:0] x1,
        input logic [FRAC_W-1:0]        f
    );
        logic signed [PW-1:0] diff;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] acc;
        diff = PW'(x1) - PW'(x0);
        prod = $signed({{(PW-FRAC_W){1'b0}}, f}) * diff;
        acc  = PW'(x0) + (prod >>> FRAC_W);
        return $signed(acc[DATA_W-1:0]);
    endfunction
`endif

    logic [ADDR_W-1:0] wptr;
    logic [DLY_W-1:0]  shadow [NUM_CH];
    logic [DLY_W-1:0]  active [NUM_CH];
    logic [VEC_W-1:0]  dly_out;

    logic              cfg_hit;
    logic              cfg_over;
    logic [DLY_W-1:0]  cfg_store;

    assign cfg_hit   = cfg_we && (int'(cfg_ch) < NUM_CH);
    assign cfg_over  = int'(cfg_delay[DLY_W-1:FRAC_W]) > MAX_D;
    assign cfg_store = cfg_over ? {ADDR_W'(MAX_D), {FRAC_W{1'b0}}} : cfg_delay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= '0;
            end
            cfg_clamped <= 1'b0;
        end else if (cfg_hit) begin
            shadow[cfg_ch] <= cfg_store;
            if (cfg_over) begin
                cfg_clamped <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DLY_W-1:0]         dly;
        logic [ADDR_W-1:0]        d_int;
        logic [FRAC_W-1:0]        d_frac;
        logic [ADDR_W-1:0]        ra0;
        logic [ADDR_W-1:0]        ra1;
        logic signed [DATA_W-1:0] x_in;
        logic signed [DATA_W-1:0] rd0;
        logic signed [DATA_W-1:0] rd1;
        logic signed [DATA_W-1:0] x0;
        logic signed [DATA_W-1:0] y;

        // The accepting sample already sees the shadow that active is about to load.
        assign dly    = in_valid ? shadow[c] : active[c];
        assign d_int  = dly[DLY_W-1:FRAC_W];
        assign d_frac = dly[FRAC_W-1:0];
        assign x_in   = $signed(in_data[lane_lo(c, DATA_W) +: DATA_W]);
        assign ra0    = wptr - d_int;
        assign ra1    = wptr - d_int - ADDR_W'(1);

        delay_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk    (clk),
            .rst    (rst),
            .we     (in_valid),
            .waddr  (wptr),
            .din    (x_in),
            .raddr0 (ra0),
            .raddr1 (ra1),
            .rdata0 (rd0),
            .rdata1 (rd1)
        );

        // Zero delay means the sample being written this cycle; bypass the RAM.
        assign x0 = (d_int == '0) ? x_in : rd0;

`ifdef DELAY_FRAC_INTERP_EN
        assign y = interp(x0, rd1, d_frac);
`else
        logic unused_interp;
        assign unused_interp = ^{rd1, d_frac};
        assign y = x0;
`endif

        assign dly_out[lane_lo(c, DATA_W) +: DATA_W] = y;
    end

    // Output stage: one register between the accepted sample and out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                active[c] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                wptr     <= wptr + ADDR_W'(1);
                out_data <= dly_out;
                for (int c = 0; c < NUM_CH; c++) begin
                    active[c] <= shadow[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_multich_delay_line.sv
// Scoreboard bench for multich_delay_line; expected vectors are queued at
// issue time and checked by an independent output monitor.
module tb_multich_delay_line;
    import delay_pkg::*;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int FRAC_W = 4;
    localparam int VEC_W  = NUM_CH * DATA_W;
    localparam int DLY_W  = ADDR_W + FRAC_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [VEC_W-1:0]  in_data = '0;
    logic              out_valid;
    logic [VEC_W-1:0]  out_data;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [DLY_W-1:0]  cfg_delay = '0;
    logic              cfg_clamped;

    always #5 clk = ~clk;

    multich_delay_line #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_delay   (cfg_delay),
        .cfg_clamped (cfg_clamped)
    );

    typedef struct {
        logic [VEC_W-1:0] vec;
        int               t;
        int               k;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic vld_d;

    task automatic chk(input string nm, input int t, input int k,
                       input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t%0d s%0d got=%h exp=%h", nm, t, k, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) vld_d <= 1'b0;
        else      vld_d <= in_valid;
    end

    // Monitor: out_valid must trail in_valid by one cycle; each valid pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", -1, -1, VEC_W'(out_valid), VEC_W'(vld_d));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", -1, -1, VEC_W'(1), VEC_W'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", mon_e.t, mon_e.k, out_data, mon_e.vec);
                end
            end
        end
    end

    function automatic logic [DLY_W-1:0] dl(input int i, input int f);
        delay_t d;
        d.intg = 6'(i);
        d.frac = 4'(f);
        return d;
    endfunction

    function automatic void setl(inout logic [VEC_W-1:0] v, input int c, input int val);
        v[c*DATA_W +: DATA_W] = DATA_W'(val);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VEC_W-1:0] d, input logic [VEC_W-1:0] e,
                        input int t, input int k);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        sb.push_back('{e, t, k});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic [DLY_W-1:0] v);
        cfg_we    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_delay = v;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic chk_zero(input int t);
        chk("rst_out_valid", t, 0, VEC_W'(out_valid), '0);
        chk("rst_out_data", t, 0, out_data, '0);
        chk("rst_clamped", t, 0, VEC_W'(cfg_clamped), '0);
    endtask

    task automatic do_reset(input int t);
        idle(1);
        chk("sb_drain", t, 0, VEC_W'(sb.size()), '0);
        rst = 1'b0;
        #2;
        chk_zero(t);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
    endtask

    logic [VEC_W-1:0] din;
    logic [VEC_W-1:0] dexp;

    initial begin
        idle(2);
        chk_zero(0);
        rst = 1'b1;

        // T1: all delays 0 after reset -> output equals input
        for (int k = 0; k < 6; k++) begin
            din = '0;
            for (int c = 0; c < NUM_CH; c++) setl(din, c, k * 1000 - c * 12345);
            send(din, din, 1, k);
        end

        // T2: ramp on ch0 with delay 5, idle gaps freeze the line
        do_reset(2);
        cfg(0, dl(5, 0));
        for (int k = 0; k < 20; k++) begin
            din = '0; dexp = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                setl(din, c, (c == 0) ? k : -k * (c + 1) * 7);
                setl(dexp, c, (c == 0) ? ((k >= 5) ? k - 5 : 0) : -k * (c + 1) * 7);
            end
            send(din, dexp, 2, k);
            if (k % 4 == 3) idle(2);
        end

        // T3: 62 accepted silently, 63.5 clamps to 62.0; 70 samples cross the wrap
        do_reset(3);
        cfg(2, dl(62, 0));
        chk("clamp_62", 3, 0, VEC_W'(cfg_clamped), VEC_W'(0));
        cfg(2, dl(63, 5));
        chk("clamp_63", 3, 0, VEC_W'(cfg_clamped), VEC_W'(1));
        for (int k = 0; k < 70; k++) begin
            din = '0; dexp = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                setl(din, c, k * (c + 1) + 16 * c);
                if (c == 2) setl(dexp, c, (k >= 62) ? (k - 62) * 3 + 32 : 0);
                else        setl(dexp, c, k * (c + 1) + 16 * c);
            end
            send(din, dexp, 3, k);
        end
        chk("clamp_sticky", 3, 70, VEC_W'(cfg_clamped), VEC_W'(1));

        // T4: delay 3 -> 10, ch7 written with sample 40, rest before sample 41
        do_reset(4);
        for (int c = 0; c < NUM_CH; c++) cfg(c, dl(3, 0));
        for (int k = 0; k < 46; k++) begin
            din = '0; dexp = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                setl(din, c, k + 100 * c);
                if (k <= 40) setl(dexp, c, (k >= 3) ? (k - 3) + 100 * c : 0);
                else         setl(dexp, c, (k >= 10) ? (k - 10) + 100 * c : 0);
            end
            if (k == 40) begin
                cfg_we = 1'b1; cfg_ch = 3'd7; cfg_delay = dl(10, 0);
                send(din, dexp, 4, k);
                cfg_we = 1'b0;
                for (int c = 0; c < 7; c++) cfg(c, dl(10, 0));
            end else begin
                send(din, dexp, 4, k);
            end
        end

        // T5: delay 2.5 on ch0 (x=16k) and ch1 (x=-16k)
        do_reset(5);
        cfg(0, dl(2, 8));
        cfg(1, dl(2, 8));
        for (int k = 0; k < 10; k++) begin
            din = '0; dexp = '0;
            for (int c = 0; c < NUM_CH; c++) setl(din, c, (c == 0) ? 16 * k : (c == 1) ? -16 * k : k);
            for (int c = 2; c < NUM_CH; c++) setl(dexp, c, k);
`ifdef DELAY_FRAC_INTERP_EN
            setl(dexp, 0, (k >= 3) ? 16 * (k - 2) - 8 : 0);
            setl(dexp, 1, (k >= 3) ? -16 * (k - 2) + 8 : 0);
`else
            setl(dexp, 0, (k >= 2) ? 16 * (k - 2) : 0);
            setl(dexp, 1, (k >= 2) ? -16 * (k - 2) : 0);
`endif
            send(din, dexp, 5, k);
        end

        // T6: 130 continuous samples, reset pulsed during sample 70
        do_reset(6);
        cfg(1, dl(4, 0));
        for (int k = 0; k < 130; k++) begin
            din = '0; dexp = '0;
            for (int c = 0; c < NUM_CH; c++) setl(din, c, k + 1000 * c);
            if (k < 70) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (c == 1) setl(dexp, c, (k >= 4) ? (k - 4) + 1000 : 0);
                    else        setl(dexp, c, k + 1000 * c);
                end
                send(din, dexp, 6, k);
            end else if (k == 70) begin
                in_valid = 1'b1;
                in_data  = din;
                @(negedge clk);
                #1;
                rst = 1'b0;
                #1;
                chk_zero(6);
                @(posedge clk);
                #1;
                rst = 1'b1;
                in_valid = 1'b0;
                chk("midrst_sb", 6, k, VEC_W'(sb.size()), '0);
            end else begin
                // j: sample index since release; ch3 switches to delay 10 from j=5
                for (int c = 0; c < NUM_CH; c++) begin
                    if (c == 3 && (k - 71) >= 5) setl(dexp, c, ((k - 71) >= 10) ? (k - 10) + 3000 : 0);
                    else                         setl(dexp, c, k + 1000 * c);
                end
                if (k - 71 == 4) begin
                    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_delay = dl(10, 0);
                    send(din, dexp, 6, k);
                    cfg_we = 1'b0;
                end else begin
                    send(din, dexp, 6, k);
                end
            end
        end

        idle(3);
        chk("final_drain", 7, 0, VEC_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
